mem_fill_arbiter: RTL and testbench

- Shares the single multi-cycle unified memory (memory4c-style: pipelined reads, fixed read latency) between three requesters: I-cache miss fill, D-cache miss fill and D-side write-through stores.
- Sits between the I/D caches and main memory.
- Per request it grants one requester, sequences the burst of word reads for a full cache block and steers the returned words to the granted cache.
- For a store it issues the single write cycle and acknowledges it.

---
 rtl/mem_fill_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_fill_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fill_arbiter.sv
// Arbitrates one pipelined memory among I-fill, D-fill and D-store (fixed priority d_wr > d_miss > i_miss).
// Grant one cycle after request; a fill finishes on its last returned word; a pending request waits for IDLE.
module mem_fill_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int WORD_BITS  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_miss,
  input  logic [ADDR_WIDTH-1:0] i_miss_addr,
  input  logic                  d_miss,
  input  logic [ADDR_WIDTH-1:0] d_miss_addr,
  input  logic                  d_wr,
  input  logic [ADDR_WIDTH-1:0] d_wr_addr,
  input  logic [DATA_WIDTH-1:0] d_wr_data,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  mem_data_valid,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic [WORD_BITS-1:0]  fill_word,
  output logic                  i_fill_we,
  output logic                  d_fill_we,
  output logic                  i_fill_done,
  output logic                  d_fill_done,
  output logic                  d_wr_ack,
  output logic                  busy
);

  localparam int BASE_W = ADDR_WIDTH - WORD_BITS - 1;
  localparam logic [WORD_BITS-1:0] LAST_WORD = '1;

  typedef enum logic [1:0] {IDLE, WRITE, FILL_I, FILL_D} state_t;

  state_t                state, state_n;
  logic [WORD_BITS-1:0]  issue_cnt, issue_cnt_n;
  logic [WORD_BITS-1:0]  recv_cnt, recv_cnt_n;
  logic                  issue_done, issue_done_n;
  logic [BASE_W-1:0]     base, base_n;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_addr_n;
  logic [DATA_WIDTH-1:0] wr_data, wr_data_n;

  // Byte/word offset bits of the miss addresses are irrelevant: fills always start at word 0.
  logic unused_offset;
  assign unused_offset = ^{i_miss_addr[WORD_BITS:0], d_miss_addr[WORD_BITS:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      issue_cnt  <= '0;
      recv_cnt   <= '0;
      issue_done <= 1'b0;
      base       <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      state      <= state_n;
      issue_cnt  <= issue_cnt_n;
      recv_cnt   <= recv_cnt_n;
      issue_done <= issue_done_n;
      base       <= base_n;
      wr_addr    <= wr_addr_n;
      wr_data    <= wr_data_n;
    end
  end

  always_comb begin
    state_n      = state;
    issue_cnt_n  = issue_cnt;
    recv_cnt_n   = recv_cnt;
    issue_done_n = issue_done;
    base_n       = base;
    wr_addr_n    = wr_addr;
    wr_data_n    = wr_data;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;
    fill_data    = '0;
    fill_word    = '0;
    i_fill_we    = 1'b0;
    d_fill_we    = 1'b0;
    i_fill_done  = 1'b0;
    d_fill_done  = 1'b0;
    d_wr_ack     = 1'b0;

    case (state)
      IDLE: begin
        if (d_wr) begin
          state_n   = WRITE;
          wr_addr_n = d_wr_addr;
          wr_data_n = d_wr_data;
        end else if (d_miss) begin
          state_n = FILL_D;
          base_n  = d_miss_addr[ADDR_WIDTH-1:WORD_BITS+1];
        end else if (i_miss) begin
          state_n = FILL_I;
          base_n  = i_miss_addr[ADDR_WIDTH-1:WORD_BITS+1];
        end
      end

      WRITE: begin
        mem_en      = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = wr_addr;
        mem_data_in = wr_data;
        d_wr_ack    = 1'b1;
        state_n     = IDLE;
      end

      FILL_I, FILL_D: begin
        if (!issue_done) begin
          mem_en      = 1'b1;
          mem_addr    = {base, issue_cnt, 1'b0};
          issue_cnt_n = issue_cnt + 1'b1;
          if (issue_cnt == LAST_WORD) issue_done_n = 1'b1;
        end
        // Returned words arrive in issue order, so recv_cnt alone names the word.
        if (mem_data_valid) begin
          fill_data  = mem_data_out;
          fill_word  = recv_cnt;
          i_fill_we  = (state == FILL_I);
          d_fill_we  = (state == FILL_D);
          recv_cnt_n = recv_cnt + 1'b1;
          if (recv_cnt == LAST_WORD) begin
            i_fill_done  = (state == FILL_I);
            d_fill_done  = (state == FILL_D);
            state_n      = IDLE;
            issue_cnt_n  = '0;
            recv_cnt_n   = '0;
            issue_done_n = 1'b0;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Scoreboarded bench: directed requests push expected memory accesses and fill writes; a monitor pops and compares.
module tb_mem_fill_arbiter;

  logic        clk, rst;
  logic        i_miss, d_miss, d_wr;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_data_in, mem_data_out;
  logic        mem_data_valid;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack, busy;
  logic        force_valid;

  mem_fill_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .WORD_BITS(3)) dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr(d_wr), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
    .fill_data(fill_data), .fill_word(fill_word),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
    .d_wr_ack(d_wr_ack), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Latency-4 read pipeline returning the address as data; shares rst with the DUT.
  logic [3:0]  pv;
  logic [15:0] pa0, pa1, pa2, pa3;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0; pa0 <= '0; pa1 <= '0; pa2 <= '0; pa3 <= '0;
    end else begin
      pv  <= {pv[2:0], mem_en & ~mem_wr};
      pa0 <= mem_addr; pa1 <= pa0; pa2 <= pa1; pa3 <= pa2;
    end
  end
  assign mem_data_valid = pv[3] | force_valid;
  assign mem_data_out   = pa3;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic wr; logic [15:0] addr; logic [15:0] data; } mem_exp_t;
  typedef struct { int cyc; logic is_d; logic [2:0] word; logic [15:0] data; logic done; } fill_exp_t;
  mem_exp_t  mem_q[$];
  fill_exp_t fill_q[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // First issue at cycle t; word k is requested at t+k and written back at t+4+k.
  task automatic push_fill(input logic is_d, input logic [15:0] base, input int t,
                           input int n_iss, input int n_rcv);
    for (int k = 0; k < n_iss; k++)
      mem_q.push_back('{t + k, 1'b0, 16'(base + 2 * k), 16'h0});
    for (int k = 0; k < n_rcv; k++)
      fill_q.push_back('{t + 4 + k, is_d, 3'(k), 16'(base + 2 * k), (k == 7)});
  endtask

  always @(negedge clk) begin
    mem_exp_t  me;
    fill_exp_t fe;
    if (rst) chk("outputs_zero_in_rst", 32'(|{mem_en, mem_wr, mem_addr, mem_data_in, fill_data, fill_word,
                 i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack, busy}), 0);
    if (mem_en) begin
      chk("mem_access_expected", 32'(mem_q.size() > 0), 1);
      if (mem_q.size() > 0) begin
        me = mem_q.pop_front();
        chk("mem_cycle", me.cyc, cyc);
        chk("mem_wr", 32'(mem_wr), 32'(me.wr));
        chk("mem_addr", 32'(mem_addr), 32'(me.addr));
        if (me.wr) chk("mem_data_in", 32'(mem_data_in), 32'(me.data));
        chk("d_wr_ack", 32'(d_wr_ack), 32'(me.wr));
      end
    end else begin
      chk("ack_without_access", 32'(d_wr_ack), 0);
    end
    if (i_fill_we | d_fill_we) begin
      chk("fill_expected", 32'(fill_q.size() > 0), 1);
      if (fill_q.size() > 0) begin
        fe = fill_q.pop_front();
        chk("fill_cycle", fe.cyc, cyc);
        chk("fill_we_sel", 32'({i_fill_we, d_fill_we}), fe.is_d ? 32'h1 : 32'h2);
        chk("fill_word", 32'(fill_word), 32'(fe.word));
        chk("fill_data", 32'(fill_data), 32'(fe.data));
        chk("i_fill_done", 32'(i_fill_done), 32'(fe.done & ~fe.is_d));
        chk("d_fill_done", 32'(d_fill_done), 32'(fe.done & fe.is_d));
      end
    end else begin
      chk("done_without_we", 32'({i_fill_done, d_fill_done}), 0);
    end
  end

  // Waits for ack (0), D done (1) or I done (2), then drops that request before the next IDLE sample.
  task automatic wait_drop(input int which, input int bound);
    bit seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      case (which)
        0:       seen = d_wr_ack;
        1:       seen = d_fill_done;
        default: seen = i_fill_done;
      endcase
    end
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL wait_timeout: event %0d not seen within %0d cycles", which, bound);
    end
    case (which)
      0:       d_wr = 1'b0;
      1:       d_miss = 1'b0;
      default: i_miss = 1'b0;
    endcase
  endtask

  initial begin
    int t;
    rst = 1'b0; force_valid = 1'b0;
    i_miss = 0; d_miss = 0; d_wr = 0;
    i_miss_addr = '0; d_miss_addr = '0; d_wr_addr = '0; d_wr_data = '0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset_busy", 32'(busy), 0);
    chk("idle_after_reset_mem_en", 32'(mem_en), 0);

    // Single I fill at 0x1234.
    @(posedge clk); #1;
    i_miss = 1; i_miss_addr = 16'h1234; t = cyc;
    push_fill(1'b0, 16'h1230, t + 1, 8, 8);
    wait_drop(2, 40);
    repeat (3) @(posedge clk);

    // Simultaneous I and D misses: D wins, I starts two cycles after d_fill_done.
    @(posedge clk); #1;
    i_miss = 1; i_miss_addr = 16'h2000; d_miss = 1; d_miss_addr = 16'h0040; t = cyc;
    push_fill(1'b1, 16'h0040, t + 1, 8, 8);
    push_fill(1'b0, 16'h2000, t + 14, 8, 8);
    wait_drop(1, 40);
    wait_drop(2, 40);
    repeat (3) @(posedge clk);

    // Store raised mid-fill waits for the fill to end.
    @(posedge clk); #1;
    i_miss = 1; i_miss_addr = 16'h0500; t = cyc;
    push_fill(1'b0, 16'h0500, t + 1, 8, 8);
    mem_q.push_back('{t + 14, 1'b1, 16'h0100, 16'hBEEF});
    repeat (3) @(posedge clk); #1;
    d_wr = 1; d_wr_addr = 16'h0100; d_wr_data = 16'hBEEF;
    wait_drop(2, 40);
    wait_drop(0, 10);
    repeat (3) @(posedge clk);

    // All three together: WRITE, FILL_D, FILL_I.
    @(posedge clk); #1;
    d_wr = 1; d_wr_addr = 16'h0A0A; d_wr_data = 16'h5A5A;
    d_miss = 1; d_miss_addr = 16'h0305; i_miss = 1; i_miss_addr = 16'h060F; t = cyc;
    mem_q.push_back('{t + 1, 1'b1, 16'h0A0A, 16'h5A5A});
    push_fill(1'b1, 16'h0300, t + 3, 8, 8);
    push_fill(1'b0, 16'h0600, t + 16, 8, 8);
    wait_drop(0, 10);
    wait_drop(1, 40);
    wait_drop(2, 40);
    repeat (3) @(posedge clk);

    // Reset during cycle 6 of a D fill, then a clean I fill.
    @(posedge clk); #1;
    d_miss = 1; d_miss_addr = 16'h0080; t = cyc;
    push_fill(1'b1, 16'h0080, t + 1, 5, 1);
    repeat (6) @(posedge clk); #1;
    rst = 1'b1; d_miss = 0;
    @(negedge clk);
    chk("rst_mid_fill_busy", 32'(busy), 0);
    chk("rst_mid_fill_mem_en", 32'(mem_en), 0);
    repeat (2) @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    i_miss = 1; i_miss_addr = 16'h0010; t = cyc;
    push_fill(1'b0, 16'h0010, t + 1, 8, 8);
    wait_drop(2, 40);
    repeat (3) @(posedge clk);

    // Stray valids in IDLE must be ignored.
    @(posedge clk); #1 force_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_valid_busy", 32'(busy), 0);
      chk("stray_valid_we", 32'({i_fill_we, d_fill_we}), 0);
    end
    @(posedge clk); #1 force_valid = 1'b0;
    @(negedge clk);
    chk("stray_valid_stays_idle", 32'(busy), 0);

    repeat (5) @(posedge clk);
    chk("mem_q_drained", mem_q.size(), 0);
    chk("fill_q_drained", fill_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
